// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and
// wait-state counter sizing.
package mem_if_pkg;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request/response channel between the core (master) and the
// data-memory responder (slave).
interface dmem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);

  logic                  REQ_VALID;
  logic                  REQ_READY;
  logic                  REQ_WE;
  logic [ADDR_W-1:0]     REQ_ADDR;
  logic [DATA_W-1:0]     REQ_WDATA;
  logic [DATA_W/8-1:0]   REQ_BE;
  logic                  RSP_VALID;
  logic                  RSP_READY;
  logic [DATA_W-1:0]     RSP_RDATA;
  logic                  RSP_ERR;

  modport master (
    output REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_BE, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_BE, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

endinterface

// File: rtl/dmem_responder_array.sv
// DEPTH x DATA_W storage with per-byte write enables and an asynchronous
// read port. Contents are deliberately not reset.
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                CLK,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [DATA_W-1:0]   rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-lane write: only lanes with their enable set are updated.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, inserts
// WAIT_CYC wait states and returns read data or a write acknowledge.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_INIT | just out of reset; REQ_READY low for one cycle
//   ST_IDLE | REQ_READY high; a handshake commits stores and latches the op
//   ST_WAIT | down-counting wait states; RESP entered after counter hits 0
//   ST_RESP | RSP_VALID high; data/err held until RSP_READY
//
// The store is committed on the acceptance edge directly from the request
// bus, so store data never needs to be held. The counter is loaded with
// WAIT_CYC and WAIT is left on the edge where it is already 0, which puts
// the first response cycle WAIT_CYC+1 edges after acceptance.
module dmem_responder
  import mem_if_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int DEPTH    = 128,
  parameter int WAIT_CYC = 2
) (
  input  logic             CLK,
  input  logic             R,
  dmem_responder_if.slave  bus
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LD  = CNT_W'(WAIT_CYC);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                req_hs;
  logic                req_in_range;
  logic                cur_in_range;
  logic                wr_en;
  logic [DATA_W-1:0]   rd_data;

  assign req_hs       = (state_q == ST_IDLE) && bus.REQ_VALID;
  assign req_in_range = {1'b0, bus.REQ_ADDR} < DEPTH_X;
  assign cur_in_range = {1'b0, addr_q} < DEPTH_X;
  assign wr_en        = req_hs && bus.REQ_WE && req_in_range;

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_idx  (bus.REQ_ADDR[IDX_W-1:0]),
    .wr_data (bus.REQ_WDATA),
    .wr_be   (bus.REQ_BE),
    .rd_idx  (addr_q[IDX_W-1:0]),
    .rd_data (rd_data)
  );

  // Next-state, counter and response-register computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.REQ_VALID) begin
          we_d    = bus.REQ_WE;
          addr_d  = bus.REQ_ADDR;
          cnt_d   = CNT_LD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          rdata_d = (!we_q && cur_in_range) ? rd_data : '0;
          err_d   = !cur_in_range;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.RSP_READY) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State and response registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!R) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.REQ_READY = (state_q == ST_IDLE);
  assign bus.RSP_VALID = (state_q == ST_RESP);
  assign bus.RSP_RDATA = rdata_q;
  assign bus.RSP_ERR   = err_q;

endmodule
